// File: rtl/mem_view_ctrl.sv
// mem_view_ctrl: button-driven memory inspector feeding the dual hex display.
// Debounces up/down/load buttons into a 16-bit inspection address, reads the
// word at that address over a req/ack port (on change and on a periodic
// refresh, with a timeout), and presents registered address/data words.
module mem_view_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REFRESH_CYCLES  = 5000000,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_load,
    input  logic [15:0] sw,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic        rd_ack,
    input  logic [15:0] rd_data,
    output logic [15:0] disp_addr,
    output logic [15:0] disp_data,
    output logic        busy,
    output logic        timeout_err
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RF_W = $clog2(REFRESH_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    // Button bit positions inside the packed button vectors.
    localparam int B_UP   = 0;
    localparam int B_DOWN = 1;
    localparam int B_LOAD = 2;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t          state;
    logic [2:0]      btn_raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      deb;
    logic [2:0]      deb_q;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];
    logic [15:0]     cur_addr;
    logic [15:0]     next_addr;
    logic            addr_upd;
    logic [RF_W-1:0] refresh_cnt;
    logic            tick;
    logic [TO_W-1:0] to_cnt;
    logic            dirty;
    logic            launch;

    assign btn_raw = {btn_load, btn_down, btn_up};

    // Press pulse: one cycle on the rising edge of each debounced level.
    assign press = deb & ~deb_q;

    // Synchronize raw buttons and debounce each one with its own counter.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would chain sync1 into sync2 in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Next inspection address: load beats up/down; up and down together cancel.
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        next_addr = cur_addr;
        addr_upd  = 1'b0;
        if (press[B_LOAD]) begin
            next_addr = sw;
            addr_upd  = 1'b1;
        end else if (press[B_UP] ^ press[B_DOWN]) begin
            next_addr = press[B_UP] ? cur_addr + 16'd1 : cur_addr - 16'd1;
            addr_upd  = 1'b1;
        end
    end

    // Register the inspection address and its displayed copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            disp_addr <= '0;
        end else begin
            cur_addr  <= next_addr;
            disp_addr <= next_addr;
        end
    end

    // Free-running refresh timer; tick marks its last count.
    always_ff @(posedge clk) begin
        if (!rst_n)
            refresh_cnt <= '0;
        else if (tick)
            refresh_cnt <= '0;
        else
            refresh_cnt <= refresh_cnt + RF_W'(1);
    end

    assign tick   = (refresh_cnt == RF_W'(REFRESH_CYCLES - 1));
    assign launch = (state == IDLE) && (dirty || tick);

    // Read FSM: issue reads when dirty or on refresh, accept/timeout in REQ.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            disp_data   <= '0;
            dirty       <= 1'b1;
            to_cnt      <= '0;
        end else begin
            // A fresh address change always wins over the clear at launch.
            if (addr_upd)
                dirty <= 1'b1;
            else if (launch)
                dirty <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (dirty || tick) begin
                        rd_addr <= cur_addr;
                        rd_req  <= 1'b1;
                        busy    <= 1'b1;
                        to_cnt  <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (rd_ack) begin
                        rd_req      <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b0;
                        // Data for an address the user already left is stale;
                        // dirty is set, so a fresh read follows.
                        if (rd_addr == cur_addr)
                            disp_data <= rd_data;
                        state <= IDLE;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        rd_req      <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
